// File: rtl/req_priority_arbiter_if.sv
// ---------------------------------------------------------------------------
// req_priority_arbiter_if
//   Bundles the requester-side handshake and the grant outputs of the
//   8-way arbiter. Clock and reset stay outside as plain module ports.
//
//   Signals:
//     req[7:0]       request vector, bit i = requester i
//     done           release pulse from the current owner
//     grant[7:0]     one-hot grant, zero when nobody owns the resource
//     grant_idx[2:0] binary index of the owner, zero when none
//     busy           high while a grant is held
//     timeout        one-cycle pulse when a grant was revoked by hold expiry
//
//   Modports:
//     master  requesting side (drives req/done, observes grant status)
//     slave   arbiter side    (observes req/done, drives grant status)
// ---------------------------------------------------------------------------
interface req_priority_arbiter_if;
  logic [7:0] req;
  logic       done;
  logic [7:0] grant;
  logic [2:0] grant_idx;
  logic       busy;
  logic       timeout;

  modport master (
    output req,
    output done,
    input  grant,
    input  grant_idx,
    input  busy,
    input  timeout
  );

  modport slave (
    input  req,
    input  done,
    output grant,
    output grant_idx,
    output busy,
    output timeout
  );
endinterface

// File: rtl/req_priority_arbiter.sv
// ---------------------------------------------------------------------------
// req_priority_arbiter
//   Shares one downstream resource among 8 requesters. While idle it picks a
//   winner from req (bit 7 highest), then holds a one-hot grant until the
//   owner pulses done, drops its request, or the hold limit expires. Every
//   release is followed by one cool cycle before arbitration resumes.
//   grant_idx drives the datapath select mux. All outputs are registered;
//   there is no combinational path from req/done to any output.
//
//   Parameters:
//     MAX_HOLD  maximum cycles a grant may be held (0 = no limit)
//     CNT_W     hold counter width, 2**CNT_W must exceed MAX_HOLD
//
//   Ports:
//     clk   rising-edge clock
//     rst   asynchronous active-high reset
//     bus   req_priority_arbiter_if.slave (req, done in; grant, grant_idx,
//           busy, timeout out)
//
//   Build option:
//     ARB_ROUND_ROBIN_EN  when defined, selection rotates: a pointer holds
//                         the last granted index and the search runs
//                         p-1, p-2, ... down to p (mod 8). When undefined the
//                         selection is pure fixed priority and no pointer
//                         register exists.
//
//   state | meaning
//   ------+-----------------------------------------------------------------
//   IDLE  | no owner; a non-zero req at the edge latches a winner
//   GRANT | owner holds grant; hold counter runs from 1
//   COOL  | single dead cycle after release, outputs zero, then IDLE
// ---------------------------------------------------------------------------
module req_priority_arbiter #(
  parameter int MAX_HOLD = 16,
  parameter int CNT_W    = 5
) (
  input  logic                   clk,
  input  logic                   rst,
  req_priority_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_COOL  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] HOLD_LIM = CNT_W'(MAX_HOLD);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t           state_q, state_d;
  logic [7:0]       grant_q, grant_d;
  logic [2:0]       idx_q, idx_d;
  logic             busy_q, busy_d;
  logic             timeout_q, timeout_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [2:0]       win_idx;
  logic             rel_done;
  logic             rel_drop;
  logic             rel_tmo;
  logic             release_now;

  // -------------------------------------------------------------------------
  // Winner selection
  // -------------------------------------------------------------------------
`ifdef ARB_ROUND_ROBIN_EN
  logic [2:0] ptr_q, ptr_d;
  logic [2:0] cand;

  // Scan from the far end (p-8 == p) towards p-1 so the last hit, i.e. the
  // candidate closest to p-1, is the one that sticks.
  always_comb begin
    win_idx = 3'd0;
    cand    = 3'd0;
    for (int k = 8; k >= 1; k--) begin
      cand = ptr_q - 3'(k);
      if (bus.req[cand]) begin
        win_idx = cand;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q <= 3'd0;
    end else begin
      ptr_q <= ptr_d;
    end
  end
`else
  // Ascending scan: the highest set bit is the last hit and wins.
  always_comb begin
    win_idx = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (bus.req[i]) begin
        win_idx = 3'(i);
      end
    end
  end
`endif

  // -------------------------------------------------------------------------
  // Release causes, only meaningful while in GRANT
  // -------------------------------------------------------------------------
  assign rel_done    = bus.done;
  assign rel_drop    = ~bus.req[idx_q];
  assign rel_tmo     = (MAX_HOLD != 0) && (cnt_q == HOLD_LIM);
  assign release_now = rel_done | rel_drop | rel_tmo;

  // -------------------------------------------------------------------------
  // State and output registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      grant_q   <= 8'd0;
      idx_q     <= 3'd0;
      busy_q    <= 1'b0;
      timeout_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      idx_q     <= idx_d;
      busy_q    <= busy_d;
      timeout_q <= timeout_d;
      cnt_q     <= cnt_d;
    end
  end

  // -------------------------------------------------------------------------
  // Next state and next registered outputs. Outputs default to zero so that
  // COOL and IDLE need no explicit clearing.
  // -------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    grant_d   = 8'd0;
    idx_d     = 3'd0;
    busy_d    = 1'b0;
    timeout_d = 1'b0;
    cnt_d     = '0;
`ifdef ARB_ROUND_ROBIN_EN
    ptr_d     = ptr_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (bus.req != 8'd0) begin
          state_d = ST_GRANT;
          grant_d = 8'd1 << win_idx;
          idx_d   = win_idx;
          busy_d  = 1'b1;
          cnt_d   = CNT_ONE;
`ifdef ARB_ROUND_ROBIN_EN
          ptr_d   = win_idx;
`endif
        end
      end

      ST_GRANT: begin
        if (release_now) begin
          state_d   = ST_COOL;
          // Expiry is only reported when it is the sole reason for release.
          timeout_d = rel_tmo & ~rel_done & ~rel_drop;
        end else begin
          grant_d = grant_q;
          idx_d   = idx_q;
          busy_d  = 1'b1;
          // Saturate so an unlimited hold (MAX_HOLD == 0) never wraps.
          cnt_d   = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_ONE;
        end
      end

      ST_COOL: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign bus.grant     = grant_q;
  assign bus.grant_idx = idx_q;
  assign bus.busy      = busy_q;
  assign bus.timeout   = timeout_q;

endmodule

// File: tb/tb_req_priority_arbiter.sv
module tb_req_priority_arbiter;

  localparam int MAX_HOLD = 4;
  localparam int CNT_W    = 5;

  logic clk;
  logic rst;

  req_priority_arbiter_if bus();

  req_priority_arbiter #(
    .MAX_HOLD (MAX_HOLD),
    .CNT_W    (CNT_W)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // {grant, grant_idx, busy, timeout}
  function automatic logic [12:0] outs();
    return {bus.grant, bus.grant_idx, bus.busy, bus.timeout};
  endfunction

  task automatic chk(input string nm, input logic [12:0] act, input logic [12:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual{grant,idx,busy,tmo}=%h/%0d/%0d/%0d required=%h/%0d/%0d/%0d",
               nm, act[12:5], act[4:2], act[1], act[0], exp[12:5], exp[4:2], exp[1], exp[0]);
    end
  endtask

  // -------------------------------------------------------------------------
  // Directed vectors: inputs held during one cycle, outputs expected after
  // the following rising edge.
  // -------------------------------------------------------------------------
  typedef struct {
    logic [7:0] req;
    logic       done;
    logic [7:0] g;
    logic [2:0] idx;
    logic       tmo;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic [7:0] r, input logic d, input logic [7:0] g,
                     input logic [2:0] i, input logic t);
    vec_t v;
    v.req = r; v.done = d; v.g = g; v.idx = i; v.tmo = t;
    vecs.push_back(v);
  endtask

  // -------------------------------------------------------------------------
  // Reference model: tracks owner / hold length / cool flag directly.
  // -------------------------------------------------------------------------
  int m_owner;
  int m_held;
  bit m_cool;
  bit m_tmo;
  int m_ptr;

  task automatic model_reset();
    m_owner = -1; m_held = 0; m_cool = 0; m_tmo = 0; m_ptr = 0;
  endtask

  function automatic int pick(input logic [7:0] r);
    int w;
    w = -1;
`ifdef ARB_ROUND_ROBIN_EN
    for (int k = 1; k <= 8; k++) begin
      int c;
      c = (m_ptr - k + 16) % 8;
      if (w < 0 && r[c]) w = c;
    end
`else
    for (int i = 7; i >= 0; i--) begin
      if (w < 0 && r[i]) w = i;
    end
`endif
    return w;
  endfunction

  task automatic model_step(input logic [7:0] r, input logic d);
    m_tmo = 0;
    if (m_owner >= 0) begin
      bit drop, expd;
      drop = (r[m_owner] == 1'b0);
      expd = (MAX_HOLD != 0) && (m_held == MAX_HOLD);
      if (d || drop || expd) begin
        m_tmo   = expd && !d && !drop;
        m_owner = -1;
        m_cool  = 1;
      end else if (m_held < (1 << CNT_W) - 1) begin
        m_held++;
      end
    end else if (m_cool) begin
      m_cool = 0;
    end else if (r != 8'd0) begin
      m_owner = pick(r);
      m_held  = 1;
      m_ptr   = m_owner;
    end
  endtask

  function automatic logic [12:0] model_outs();
    logic [7:0] g;
    logic [2:0] i;
    g = 8'd0; i = 3'd0;
    if (m_owner >= 0) begin
      g = 8'd1 << m_owner;
      i = 3'(m_owner);
    end
    return {g, i, (m_owner >= 0) ? 1'b1 : 1'b0, m_tmo};
  endfunction

  task automatic cycle(input logic [7:0] r, input logic d);
    bus.req  = r;
    bus.done = d;
    @(posedge clk);
    #1;
  endtask

  logic [7:0] rq;
  logic       dn;

  initial begin
    rst      = 1'b1;
    bus.req  = 8'd0;
    bus.done = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("reset_state", outs(), 13'd0);
    rst = 1'b0;

    // idle with no requests
    for (int k = 0; k < 5; k++) add(8'h00, 0, 8'h00, 3'd0, 0);

    // 0101_0010 held, done during the 3rd grant cycle
    add(8'h52, 0, 8'h40, 3'd6, 0);
    add(8'h52, 0, 8'h40, 3'd6, 0);
    add(8'h52, 0, 8'h40, 3'd6, 0);
    add(8'h52, 1, 8'h00, 3'd0, 0);
    add(8'h52, 0, 8'h00, 3'd0, 0);
`ifdef ARB_ROUND_ROBIN_EN
    add(8'h52, 0, 8'h10, 3'd4, 0);
`else
    add(8'h52, 0, 8'h40, 3'd6, 0);
`endif
    add(8'h00, 0, 8'h00, 3'd0, 0);
    add(8'h00, 0, 8'h00, 3'd0, 0);
    add(8'h00, 0, 8'h00, 3'd0, 0);

    // hold expiry: exactly MAX_HOLD grant cycles, then timeout in COOL
    add(8'h08, 0, 8'h08, 3'd3, 0);
    add(8'h08, 0, 8'h08, 3'd3, 0);
    add(8'h08, 0, 8'h08, 3'd3, 0);
    add(8'h08, 0, 8'h08, 3'd3, 0);
    add(8'h08, 0, 8'h00, 3'd0, 1);
    add(8'h08, 0, 8'h00, 3'd0, 0);
    add(8'h08, 0, 8'h08, 3'd3, 0);
    // done coinciding with expiry on the 4th cycle: no timeout
    add(8'h08, 0, 8'h08, 3'd3, 0);
    add(8'h08, 0, 8'h08, 3'd3, 0);
    add(8'h08, 0, 8'h08, 3'd3, 0);
    add(8'h08, 1, 8'h00, 3'd0, 0);
    add(8'h00, 0, 8'h00, 3'd0, 0);
    add(8'h00, 0, 8'h00, 3'd0, 0);

    // no preemption: req[7] rises while 2 owns, then 2 drops
    add(8'h04, 0, 8'h04, 3'd2, 0);
    add(8'h04, 0, 8'h04, 3'd2, 0);
    add(8'h84, 0, 8'h04, 3'd2, 0);
    add(8'h80, 0, 8'h00, 3'd0, 0);
    add(8'h80, 0, 8'h00, 3'd0, 0);
    add(8'h80, 0, 8'h80, 3'd7, 0);
    add(8'h00, 0, 8'h00, 3'd0, 0);
    add(8'h00, 0, 8'h00, 3'd0, 0);

    // request drop coinciding with expiry: no timeout
    add(8'h01, 0, 8'h01, 3'd0, 0);
    add(8'h01, 0, 8'h01, 3'd0, 0);
    add(8'h01, 0, 8'h01, 3'd0, 0);
    add(8'h01, 0, 8'h01, 3'd0, 0);
    add(8'h00, 0, 8'h00, 3'd0, 0);
    add(8'h00, 0, 8'h00, 3'd0, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      cycle(vecs[i].req, vecs[i].done);
      chk($sformatf("vec%0d", i), outs(),
          {vecs[i].g, vecs[i].idx, (vecs[i].g != 8'd0) ? 1'b1 : 1'b0, vecs[i].tmo});
    end

    // async reset mid-grant, then regrant from a cleared pointer
    cycle(8'h21, 0);
    chk("pre_reset_grant", outs(), {8'h20, 3'd5, 1'b1, 1'b0});
    #2;
    rst = 1'b1;
    #1;
    chk("async_reset_drop", outs(), 13'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    cycle(8'h21, 0);
    chk("post_reset_regrant", outs(), {8'h20, 3'd5, 1'b1, 1'b0});

    // randomized run against the reference model
    rst = 1'b1;
    bus.req = 8'd0; bus.done = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    rq = 8'd0;
    for (int n = 0; n < 3000; n++) begin
      for (int b = 0; b < 8; b++) begin
        if ($urandom_range(0, 9) == 0) rq[b] = ~rq[b];
      end
      dn = ($urandom_range(0, 5) == 0);
      if ($urandom_range(0, 399) == 0) begin
        rst = 1'b1;
        #1;
        model_reset();
        chk("rand_async_reset", outs(), 13'd0);
        rst = 1'b0;
      end
      cycle(rq, dn);
      model_step(rq, dn);
      chk($sformatf("rand%0d", n), outs(), model_outs());
      if ((bus.grant & (bus.grant - 8'd1)) != 8'd0 ||
          bus.busy != (bus.grant != 8'd0) ||
          (bus.busy && bus.grant != (8'd1 << bus.grant_idx))) begin
        chk($sformatf("invariant%0d", n), outs(), model_outs() ^ 13'h1000);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
